// File: rtl/mips_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_loader_pkg
// Brief    : Shared state encoding, Avalon response codes and defaults for
//            the MIPS program loader.
// Revision : 1.0
// ============================================================================
package mips_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_t;

    localparam logic [1:0]  RESP_OKAY           = 2'b00;
    localparam logic [1:0]  RESP_SLVERR         = 2'b10;
    localparam logic [1:0]  RESP_DECERR         = 2'b11;
    localparam logic [31:0] c_default_base_addr = 32'hBFC0_0000;

    // The reserved code 01 is treated as a fault as well.
    function automatic logic resp_is_fault(input logic [1:0] resp);
        case (resp)
            RESP_OKAY:   return 1'b0;
            RESP_SLVERR: return 1'b1;
            RESP_DECERR: return 1'b1;
            default:     return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_loader_avalon_port.sv
`default_nettype none
// ============================================================================
// Module   : mips_loader_avalon_port
// Brief    : Avalon master holding register; keeps address/data stable while
//            stalled and pulses accepted on the completing cycle.
// Revision : 1.0
// ============================================================================
module mips_loader_avalon_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_write,
    input  logic        issue_read,
    input  logic [31:0] req_address,
    input  logic [31:0] req_writedata,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [1:0]  response,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        accepted,
    output logic [1:0]  acc_response,
    output logic [31:0] acc_readdata
);

    assign busy         = write | read;
    assign accepted     = busy & ~waitrequest;
    assign acc_response = response;
    assign acc_readdata = readdata;

    // Issue is only requested while idle, so it never collides with accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address    <= 32'h0;
            byteenable <= 4'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= 32'h0;
        end else if (accepted) begin
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'h0;
        end else if (issue_write) begin
            address    <= req_address;
            writedata  <= req_writedata;
            byteenable <= 4'hF;
            write      <= 1'b1;
        end else if (issue_read) begin
            address    <= req_address;
            byteenable <= 4'hF;
            read       <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_program_loader
// Brief    : Streams program words into Avalon memory from BASE_ADDR, then
//            releases the CPU. Readback verify: define MIPS_LOADER_READBACK_EN.
// Revision : 1.0
// ============================================================================
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR         = c_default_base_addr,
    parameter int          MAX_WORDS         = 1024,
    parameter int          RESET_HOLD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_data,
    input  logic                           in_last,
    output logic [31:0]                    address,
    output logic [3:0]                     byteenable,
    output logic                           read,
    output logic                           write,
    output logic [31:0]                    writedata,
    input  logic                           waitrequest,
    input  logic [31:0]                    readdata,
    input  logic [1:0]                     response,
    output logic                           loading,
    output logic                           cpu_reset,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

    localparam int c_cnt_w  = $clog2(MAX_WORDS + 1);
    localparam int c_hold_w = (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0]  c_max_cnt  = c_cnt_w'(MAX_WORDS);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(RESET_HOLD_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

    loader_state_t       r_state;
    loader_state_t       w_next_state;
    logic [31:0]         r_addr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_last;
    logic                w_in_ready;
    logic                w_issue_write;
    logic                w_issue_read;
    logic                w_busy;
    logic                w_accepted;
    logic [1:0]          w_acc_resp;
    logic [31:0]         w_acc_rdata;

`ifdef MIPS_LOADER_READBACK_EN
    logic [31:0]         r_wr_csum;
    logic [31:0]         r_rd_csum;
    logic [c_cnt_w-1:0]  r_vidx;
    logic [31:0]         w_rd_csum_next;

    assign w_rd_csum_next = r_rd_csum ^ w_acc_rdata;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^w_acc_rdata;
`endif

    mips_loader_avalon_port u_port (
        .clk           (clk),
        .reset         (reset),
        .issue_write   (w_issue_write),
        .issue_read    (w_issue_read),
        .req_address   (r_addr),
        .req_writedata (in_data),
        .address       (address),
        .byteenable    (byteenable),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .response      (response),
        .readdata      (readdata),
        .busy          (w_busy),
        .accepted      (w_accepted),
        .acc_response  (w_acc_resp),
        .acc_readdata  (w_acc_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_in_ready    = 1'b0;
        w_issue_write = 1'b0;
        w_issue_read  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (!w_busy) begin
                    // The word beyond MAX_WORDS is refused and faults at once.
                    if (r_count == c_max_cnt) begin
                        if (in_valid) w_next_state = ST_ERROR;
                    end else begin
                        w_in_ready    = 1'b1;
                        w_issue_write = in_valid;
                    end
                end
                if (w_accepted) begin
                    if (resp_is_fault(w_acc_resp)) begin
                        w_next_state = ST_ERROR;
                    end else if (r_last) begin
`ifdef MIPS_LOADER_READBACK_EN
                        w_next_state = ST_VERIFY;
`else
                        w_next_state = ST_RELEASE;
`endif
                    end
                end
            end
`ifdef MIPS_LOADER_READBACK_EN
            ST_VERIFY: begin
                if (!w_busy && (r_vidx != r_count)) w_issue_read = 1'b1;
                if (w_accepted) begin
                    if (resp_is_fault(w_acc_resp)) begin
                        w_next_state = ST_ERROR;
                    end else if ((r_vidx + c_cnt_one) == r_count) begin
                        w_next_state = (w_rd_csum_next == r_wr_csum) ? ST_RELEASE : ST_ERROR;
                    end
                end
            end
`endif
            ST_RELEASE: begin
                if (r_hold_cnt == c_hold_max) w_next_state = ST_DONE;
            end
            ST_DONE:  w_next_state = ST_DONE;
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= 32'h0;
            r_count    <= '0;
            r_last     <= 1'b0;
            r_hold_cnt <= '0;
`ifdef MIPS_LOADER_READBACK_EN
            r_wr_csum  <= 32'h0;
            r_rd_csum  <= 32'h0;
            r_vidx     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= BASE_ADDR;
                        r_count <= '0;
                        r_last  <= 1'b0;
`ifdef MIPS_LOADER_READBACK_EN
                        r_wr_csum <= 32'h0;
`endif
                    end
                end
                ST_WRITE: begin
                    if (w_issue_write) r_last <= in_last;
                    if (w_accepted) begin
                        r_count <= r_count + c_cnt_one;
                        r_addr  <= r_addr + 32'd4;
`ifdef MIPS_LOADER_READBACK_EN
                        r_wr_csum <= r_wr_csum ^ writedata;
                        // Rewind for the readback pass.
                        if (w_next_state == ST_VERIFY) begin
                            r_addr    <= BASE_ADDR;
                            r_vidx    <= '0;
                            r_rd_csum <= 32'h0;
                        end
`endif
                    end
                end
`ifdef MIPS_LOADER_READBACK_EN
                ST_VERIFY: begin
                    if (w_accepted) begin
                        r_vidx    <= r_vidx + c_cnt_one;
                        r_addr    <= r_addr + 32'd4;
                        r_rd_csum <= w_rd_csum_next;
                    end
                end
`endif
                default: ;
            endcase
            r_hold_cnt <= (r_state == ST_RELEASE) ? (r_hold_cnt + c_hold_one) : '0;
        end
    end

    assign in_ready   = w_in_ready;
    assign loading    = (r_state == ST_WRITE) || (r_state == ST_VERIFY);
    assign cpu_reset  = (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mips_program_loader
// Brief    : Scoreboard bench with a behavioural Avalon slave and random
//            program streams.
// Revision : 1.0
// ============================================================================
module tb_mips_program_loader;

    localparam int          MAXW = 6;
    localparam int          HOLD = 4;
    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, in_last;
    logic [31:0] in_data, address, writedata, readdata;
    logic [3:0]  byteenable;
    logic        read, write, waitrequest;
    logic [1:0]  response;
    logic        loading, cpu_reset, done, error;
    logic [2:0]  word_count;

    always #5 clk = ~clk;

    mips_program_loader #(
        .BASE_ADDR         (BASE),
        .MAX_WORDS         (MAXW),
        .RESET_HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .address     (address),
        .byteenable  (byteenable),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .response    (response),
        .loading     (loading),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error),
        .word_count  (word_count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog[$];
    logic [31:0] mem[0:7];
    int          checks = 0, failures = 0;
    int          cyc = 0, stall_mode = 0, stall_left = 0, err_at = -1;
    int          acc_no = 0, acc_edge = 0, fall_edge = -1, err_edge = -1;
    int          read_acc = 0, read_seen = 0;
    bit          busy_seen = 0, corrupt = 0, done_seen = 0, prev_pending = 0;
    logic [31:0] prev_addr, prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural Avalon slave: stall profile per request, response and readback.
    initial begin
        waitrequest = 1'b0;
        response    = 2'b00;
        readdata    = 32'h0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (write || read) begin
                if (!busy_seen) begin
                    busy_seen  = 1;
                    stall_left = (stall_mode == 0) ? 0 : (stall_mode == 1) ? 3 :
                                 (stall_mode == 2) ? int'($urandom_range(0, 3)) : 1000;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
                waitrequest = (stall_left > 0);
            end else begin
                busy_seen   = 0;
                waitrequest = 1'b0;
            end
            response = (write && acc_no == err_at) ? 2'b11 : 2'b00;
            readdata = mem[address[4:2]] ^ ((corrupt && address[4:2] == 3'd1) ? 32'h100 : 32'h0);
        end
    end

    // Monitor: pops the scoreboard on every accepted write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) done_seen = 1;
                if (error && err_edge < 0) err_edge = cyc;
                if (!cpu_reset && fall_edge < 0) fall_edge = cyc;
                if (read) read_seen++;
                if (read && !waitrequest) read_acc++;
                if (write) begin
                    chk("in_ready_while_pending", {31'h0, in_ready}, 32'h0);
                    if (prev_pending) begin
                        chk("stall_addr_stable", address, prev_addr);
                        chk("stall_data_stable", writedata, prev_data);
                    end
                    if (!waitrequest) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write", 32'h1, 32'h0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_addr", address, e.addr);
                            chk("wr_data", writedata, e.data);
                            chk("wr_byteenable", {28'h0, byteenable}, 32'hF);
                        end
                        mem[address[4:2]] = writedata;
                        acc_no++;
                        acc_edge     = cyc + 1;
                        prev_pending = 0;
                    end else begin
                        prev_pending = 1;
                        prev_addr    = address;
                        prev_data    = writedata;
                    end
                end else begin
                    prev_pending = 0;
                end
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
        prev_pending = 0;
        #1;
        chk("rst_address", address, 32'h0);
        chk("rst_byteenable", {28'h0, byteenable}, 32'h0);
        chk("rst_rw", {30'h0, read, write}, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_flags", {28'h0, loading, cpu_reset, done, error}, 32'h4);
        chk("rst_word_count", {29'h0, word_count}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_word(input int idx, input bit last, output bit captured);
        captured = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = prog[idx];
        in_last  = last;
        for (int t = 0; t < 100; t++) begin
            if (error) break;
            if (in_ready) begin
                @(posedge clk);
                captured = 1;
                exp_q.push_back('{addr: BASE + 32'(4 * idx), data: prog[idx]});
                break;
            end
            @(negedge clk);
        end
        if (!captured && !error) chk("handshake_timeout", 32'h1, 32'h0);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_load(input int n, input int mode, input int err_idx,
                            input bit no_last, input bit expect_err);
        bit cap;
        int t;
        do_reset();
        stall_mode = mode; err_at = err_idx; acc_no = 0; read_acc = 0; read_seen = 0;
        fall_edge = -1; err_edge = -1; done_seen = 0;
        exp_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_to_in_ready", {31'h0, in_ready}, 32'h1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (error) break;
            if (i >= MAXW) begin
                t = 0;
                while (write && t < 50) begin @(negedge clk); t++; end
                in_valid = 1'b1;
                in_data  = prog[i];
                chk("overflow_refused", {31'h0, in_ready}, 32'h0);
                @(negedge clk);
                chk("overflow_error_next", {31'h0, error}, 32'h1);
                chk("overflow_word_count", {29'h0, word_count}, MAXW);
                in_valid = 1'b0;
                break;
            end
            send_word(i, !no_last && (i == n - 1), cap);
            if (!cap) break;
        end
        if (expect_err) begin
            t = 0;
            while (!error && t < 200) begin @(negedge clk); t++; end
            chk("error_set", {31'h0, error}, 32'h1);
            chk("error_cpu_reset", {31'h0, cpu_reset}, 32'h1);
            chk("error_bus_idle", {29'h0, read, write, loading}, 32'h0);
            if (err_idx >= 0) begin
                chk("error_one_cycle", err_edge, acc_edge);
                chk("error_acc_count", acc_no, err_idx + 1);
            end
            repeat (8) @(negedge clk);
            chk("error_sticky", {31'h0, error}, 32'h1);
            chk("error_no_done", {31'h0, done_seen}, 32'h0);
        end else begin
            t = 0;
            while (!done && t < 300) begin @(negedge clk); t++; end
            chk("done_set", {30'h0, done, error}, 32'h2);
            chk("final_word_count", {29'h0, word_count}, n);
            chk("final_cpu_reset_loading", {30'h0, cpu_reset, loading}, 32'h0);
            chk("writes_exactly_once", acc_no, n);
`ifdef MIPS_LOADER_READBACK_EN
            chk("readback_count", read_acc, n);
`else
            chk("release_latency", fall_edge - acc_edge, HOLD + 1);
            chk("read_never", read_seen, 0);
`endif
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            @(negedge clk);
            chk("start_ignored_in_done", {29'h0, done, loading, in_ready}, 32'h4);
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit cap;
        int t;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;

        prog = '{32'h24020005, 32'h00000008, 32'h00000000};
        run_load(3, 0, -1, 0, 0);
        run_load(3, 1, -1, 0, 0);
        run_load(3, 0, 1, 0, 1);

        prog.delete();
        for (int i = 0; i < MAXW + 1; i++) prog.push_back($urandom);
        run_load(MAXW + 1, 2, -1, 1, 1);
        run_load(MAXW, 2, -1, 0, 0);

        // Reset in the middle of a stalled write, then a clean reload.
        do_reset();
        stall_mode = 3; exp_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_word(0, 1'b0, cap);
        t = 0;
        while (!(write && waitrequest) && t < 20) begin @(negedge clk); t++; end
        chk("stall_reached", {30'h0, write, waitrequest}, 32'h3);
        #2;
        do_reset();
        run_load(MAXW, 0, -1, 0, 0);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, MAXW);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            run_load(n, $urandom_range(0, 2), -1, 0, 0);
        end

`ifdef MIPS_LOADER_READBACK_EN
        prog = '{32'h24020005, 32'h00000008, 32'h00000000};
        corrupt = 1;
        run_load(3, 0, -1, 0, 1);
        chk("corrupt_read_count", read_acc, 3);
        corrupt = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
